// File: rtl/exec_stage_if.sv
// Operation issue and register-file write-back bus for the execute stage.
// The master drives the decoded operation; the slave returns ready and the write-back.
interface exec_stage_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          valid_in;
  logic [3:0]    opcode;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [AW-1:0] dest_in;
  logic          ready;
  logic          reg_wrt;
  logic [AW-1:0] dest;
  logic [DW-1:0] data;
  logic          zero_flag;
  logic          carry_flag;

  modport master (
    output valid_in, opcode, op_a, op_b, dest_in,
    input  ready, reg_wrt, dest, data, zero_flag, carry_flag
  );

  modport slave (
    input  valid_in, opcode, op_a, op_b, dest_in,
    output ready, reg_wrt, dest, data, zero_flag, carry_flag
  );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops (latency 1) plus iterative MUL/DIV (latency DW).
// Backpressure: ready drops for the whole MUL/DIV iteration and returns on its write-back edge.
module exec_stage #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  exec_stage_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ITER = 1'b1;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;

  logic [0:0]      state;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic [AW-1:0]   dest_r;
  logic [DW-1:0]   work_a;
  logic [DW-1:0]   work_b;
  logic [DW-1:0]   rem;
  logic [2*DW-1:0] prod;

  logic [DW-1:0]   alu_res;
  logic            alu_cy;
  logic            alu_wr;
  logic [DW:0]     ext;
  logic [2:0]      sh;

  logic [2*DW-1:0] mul_next;
  logic [DW:0]     div_sh;
  logic [DW:0]     div_diff;
  logic            div_ge;
  logic [DW-1:0]   rem_next;
  logic [DW-1:0]   quo_next;
  logic [DW-1:0]   fin_res;
  logic            fin_cy;

  logic            wb_fire;
  logic [DW-1:0]   wb_res;
  logic            wb_cy;
  logic [AW-1:0]   wb_dest;

  assign bus.ready = (state == IDLE);

  always_comb begin
    sh      = bus.op_b[2:0];
    ext     = '0;
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_wr  = 1'b1;
    case (bus.opcode)
      OP_ADD: begin
        ext     = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        alu_res = ext[DW-1:0];
        alu_cy  = ext[DW];
      end
      OP_SUB: begin
        alu_res = bus.op_a - bus.op_b;
        alu_cy  = (bus.op_a < bus.op_b);
      end
      OP_AND: alu_res = bus.op_a & bus.op_b;
      OP_OR:  alu_res = bus.op_a | bus.op_b;
      OP_XOR: alu_res = bus.op_a ^ bus.op_b;
      // One spare bit beside the operand catches the last bit shifted out.
      OP_SHL: begin
        ext     = {1'b0, bus.op_a} << sh;
        alu_res = ext[DW-1:0];
        alu_cy  = ext[DW];
      end
      OP_SHR: begin
        ext     = {bus.op_a, 1'b0} >> sh;
        alu_res = ext[DW:1];
        alu_cy  = ext[0];
      end
      OP_MOV: alu_res = bus.op_b;
      default: alu_wr = 1'b0;
    endcase
  end

  // MUL adds one shifted partial product per cycle; DIV shifts the quotient into work_a.
  always_comb begin
    mul_next = prod + (work_b[cnt] ? ({{DW{1'b0}}, work_a} << cnt) : '0);
    div_sh   = {rem, work_a[DW-1]};
    div_diff = div_sh - {1'b0, work_b};
    div_ge   = (div_sh >= {1'b0, work_b});
    rem_next = div_ge ? div_diff[DW-1:0] : div_sh[DW-1:0];
    quo_next = {work_a[DW-2:0], div_ge};
    if (is_div) begin
      fin_res = (work_b == '0) ? '1 : quo_next;
      fin_cy  = (work_b == '0);
    end else begin
      fin_res = mul_next[DW-1:0];
      fin_cy  = |mul_next[2*DW-1:DW];
    end
  end

  always_comb begin
    wb_fire = 1'b0;
    wb_res  = alu_res;
    wb_cy   = alu_cy;
    wb_dest = bus.dest_in;
    if (state == IDLE) begin
      wb_fire = bus.valid_in && alu_wr;
    end else if (cnt == LAST) begin
      wb_fire = 1'b1;
      wb_res  = fin_res;
      wb_cy   = fin_cy;
      wb_dest = dest_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      is_div         <= 1'b0;
      dest_r         <= '0;
      work_a         <= '0;
      work_b         <= '0;
      rem            <= '0;
      prod           <= '0;
      bus.reg_wrt    <= 1'b0;
      bus.dest       <= '0;
      bus.data       <= '0;
      bus.zero_flag  <= 1'b0;
      bus.carry_flag <= 1'b0;
    end else begin
      bus.reg_wrt <= wb_fire && (wb_dest != '0);
      if (wb_fire) begin
        bus.zero_flag  <= (wb_res == '0);
        bus.carry_flag <= wb_cy;
        // R0 is hard-wired zero: flags update but the bus keeps its last write.
        if (wb_dest != '0) begin
          bus.dest <= wb_dest;
          bus.data <= wb_res;
        end
      end
      if (state == IDLE) begin
        if (bus.valid_in && (bus.opcode == OP_MUL || bus.opcode == OP_DIV)) begin
          state  <= ITER;
          cnt    <= '0;
          is_div <= (bus.opcode == OP_DIV);
          dest_r <= bus.dest_in;
          work_a <= bus.op_a;
          work_b <= bus.op_b;
          rem    <= '0;
          prod   <= '0;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          work_a <= quo_next;
          rem    <= rem_next;
        end else begin
          prod <= mul_next;
        end
        if (cnt == LAST) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: single-cycle ops, MUL/DIV timing, R0 writes, reset abort, back-to-back.
module tb_exec_stage;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  exec_stage_if #(.DW(8), .AW(4)) bus ();

  exec_stage #(.DW(8), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] d);
    bus.valid_in = 1'b1;
    bus.opcode   = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.dest_in  = d;
  endtask

  task automatic run_single(input string tag, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [3:0] d, input logic [7:0] exp_d,
                            input logic exp_c, input logic exp_z);
    present(op, a, b, d);
    step();
    bus.valid_in = 1'b0;
    chk({tag, " reg_wrt"}, bus.reg_wrt, d != 4'd0);
    if (d != 4'd0) begin
      chk({tag, " dest"}, bus.dest, d);
      chk({tag, " data"}, bus.data, exp_d);
    end
    chk({tag, " carry"}, bus.carry_flag, exp_c);
    chk({tag, " zero"}, bus.zero_flag, exp_z);
  endtask

  task automatic run_iter(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] d, input logic [7:0] exp_d,
                          input logic exp_c, input logic exp_z);
    present(op, a, b, d);
    step();
    for (int i = 0; i < 8; i++) begin
      // Scramble the inputs while busy; nothing may be accepted or change the result.
      bus.valid_in = (i < 6);
      bus.opcode   = 4'd0;
      bus.op_a     = 8'hFF;
      bus.op_b     = 8'hFF;
      bus.dest_in  = 4'd1;
      chk($sformatf("%s ready busy %0d", tag, i), bus.ready, 1'b0);
      chk($sformatf("%s reg_wrt busy %0d", tag, i), bus.reg_wrt, 1'b0);
      step();
    end
    chk({tag, " ready done"}, bus.ready, 1'b1);
    chk({tag, " reg_wrt"}, bus.reg_wrt, 1'b1);
    chk({tag, " dest"}, bus.dest, d);
    chk({tag, " data"}, bus.data, exp_d);
    chk({tag, " carry"}, bus.carry_flag, exp_c);
    chk({tag, " zero"}, bus.zero_flag, exp_z);
  endtask

  initial begin
    logic seen_wrt;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus.valid_in = 1'b0;
    bus.opcode   = 4'd0;
    bus.op_a     = 8'h00;
    bus.op_b     = 8'h00;
    bus.dest_in  = 4'd0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset ready", bus.ready, 1'b1);
    chk("reset reg_wrt", bus.reg_wrt, 1'b0);
    chk("reset dest", bus.dest, 4'd0);
    chk("reset data", bus.data, 8'h00);
    chk("reset zero", bus.zero_flag, 1'b0);
    chk("reset carry", bus.carry_flag, 1'b0);
    #9 rst_n = 1'b1;
    step();

    run_single("add f0+20", 4'd0, 8'hF0, 8'h20, 4'd3, 8'h10, 1'b1, 1'b0);
    step();
    chk("add pulse ends", bus.reg_wrt, 1'b0);
    chk("add data held", bus.data, 8'h10);
    run_single("sub r0", 4'd1, 8'd5, 8'd5, 4'd0, 8'h00, 1'b0, 1'b1);
    run_single("sub borrow", 4'd1, 8'd3, 8'd5, 4'd2, 8'hFE, 1'b1, 1'b0);
    run_single("and", 4'd2, 8'hF0, 8'h3C, 4'd1, 8'h30, 1'b0, 1'b0);
    run_single("or", 4'd3, 8'h0F, 8'h30, 4'd1, 8'h3F, 1'b0, 1'b0);
    run_single("xor", 4'd4, 8'hA5, 8'hFF, 4'd1, 8'h5A, 1'b0, 1'b0);
    run_single("shl 1", 4'd5, 8'h81, 8'h01, 4'd2, 8'h02, 1'b1, 1'b0);
    run_single("shl 0", 4'd5, 8'h81, 8'hF8, 4'd2, 8'h81, 1'b0, 1'b0);
    run_single("shr 1", 4'd6, 8'h81, 8'h01, 4'd2, 8'h40, 1'b1, 1'b0);
    run_single("shr 3", 4'd6, 8'h06, 8'h03, 4'd2, 8'h00, 1'b1, 1'b1);
    run_single("mov", 4'd9, 8'h12, 8'h77, 4'd6, 8'h77, 1'b0, 1'b0);
    run_single("add wrap", 4'd0, 8'hFF, 8'h01, 4'd5, 8'h00, 1'b1, 1'b1);

    present(4'd12, 8'h33, 8'h44, 4'd9);
    step();
    bus.valid_in = 1'b0;
    chk("nop reg_wrt", bus.reg_wrt, 1'b0);
    chk("nop ready", bus.ready, 1'b1);
    chk("nop dest held", bus.dest, 4'd5);
    chk("nop carry held", bus.carry_flag, 1'b1);
    chk("nop zero held", bus.zero_flag, 1'b1);

    run_iter("mul 10*20", 4'd7, 8'h10, 8'h20, 4'd7, 8'h00, 1'b1, 1'b1);
    run_iter("mul 0d*0b", 4'd7, 8'h0D, 8'h0B, 4'd3, 8'h8F, 1'b0, 1'b0);
    run_iter("div 100/7", 4'd8, 8'd100, 8'd7, 4'd4, 8'd14, 1'b0, 1'b0);
    run_iter("div by 0", 4'd8, 8'd50, 8'd0, 4'd5, 8'hFF, 1'b1, 1'b0);

    // DIV completion cycle doubles as the accept cycle of the following MOV.
    run_iter("div 200/10", 4'd8, 8'd200, 8'd10, 4'd6, 8'd20, 1'b0, 1'b0);
    present(4'd9, 8'h00, 8'h55, 4'd9);
    step();
    bus.valid_in = 1'b0;
    chk("b2b mov reg_wrt", bus.reg_wrt, 1'b1);
    chk("b2b mov dest", bus.dest, 4'd9);
    chk("b2b mov data", bus.data, 8'h55);
    step();
    chk("b2b pulse ends", bus.reg_wrt, 1'b0);

    present(4'd7, 8'd3, 8'd5, 4'd8);
    step();
    bus.valid_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort busy", bus.ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort ready", bus.ready, 1'b1);
    chk("abort reg_wrt", bus.reg_wrt, 1'b0);
    chk("abort dest", bus.dest, 4'd0);
    chk("abort data", bus.data, 8'h00);
    chk("abort zero", bus.zero_flag, 1'b0);
    chk("abort carry", bus.carry_flag, 1'b0);
    #2 rst_n = 1'b1;
    seen_wrt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.reg_wrt !== 1'b0) seen_wrt = 1'b1;
    end
    chk("abort no write-back", seen_wrt, 1'b0);
    run_single("add after abort", 4'd0, 8'd1, 8'd2, 4'd2, 8'd3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter DW, default 8, meaning operand and result datapath width.
REQ-002 SHALL have parameter AW, default 4, meaning register destination index width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port valid_in  input  1  the decoded operation and operands are presented this cycle.
REQ-006 SHALL have port opcode  input  4  operation select, encoded per REQ-012.
REQ-007 SHALL have ports op_a and op_b  input  DW  operands, from register-file read ports A and B.
REQ-008 SHALL have port dest_in  input  AW  destination register index.
REQ-009 SHALL have port ready  output  1  the stage can accept an operation this cycle.
REQ-010 SHALL have ports reg_wrt (output, 1), dest (output, AW) and data (output, DW), forming the register-file write-back bus.
REQ-011 SHALL have ports zero_flag and carry_flag  output  1  status from the last completed operation.

Function
REQ-012 SHALL decode opcode as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by op_b[2:0], 6 SHR by op_b[2:0] (logical), 7 MUL, 8 DIV, 9 MOV (result = op_b), 10-15 NOP.
REQ-013 SHALL accept an operation on a rising edge where valid_in=1 and ready=1; in all other cycles inputs are ignored.
REQ-014 SHALL use FSM states IDLE and ITER: IDLE->ITER on accepting MUL or DIV; ITER->IDLE when the iteration counter reaches 7; all other accepts stay in IDLE.
REQ-015 SHALL drive ready=1 in IDLE and ready=0 in ITER.
REQ-016 SHALL register the result of ADD through MOV (except MUL and DIV) so that reg_wrt/dest/data are valid in the cycle after the accepting edge, with a latency of 1.
REQ-017 SHALL compute MUL by shift-add over 8 ITER cycles and present the result 8 edges after the accepting edge; data = product[7:0].
REQ-018 SHALL compute DIV by restoring division over 8 ITER cycles with the same timing as MUL; data = quotient.
REQ-019 SHALL capture operands and dest_in at acceptance, so that input changes during ITER have no effect.
REQ-020 SHALL assert reg_wrt for exactly one cycle per completed non-NOP operation, and keep it 0 otherwise.
REQ-021 SHALL force reg_wrt=0 when dest=0, because R0 stays zero; flags still update in that case.
REQ-022 SHALL leave reg_wrt, flags and the FSM unchanged on a NOP; ready stays 1.
REQ-023 SHALL set zero_flag = (data == 0) on each completion.
REQ-024 SHALL set carry_flag on each completion as follows:
- ADD: carry-out;
- SUB: borrow (op_a < op_b);
- SHL: last bit shifted out (0 if shift is 0);
- SHR: last bit shifted out (0 if shift is 0);
- MUL: product[15:8] != 0;
- DIV: divide-by-zero;
- AND, OR, XOR, MOV: 0.
REQ-025 SHALL produce data=8'hFF and carry_flag=1 for DIV with op_b=0, still taking 8 cycles.
REQ-026 SHALL hold data and dest at their last values when reg_wrt=0.
REQ-027 SHALL return ready=1 in the same edge that asserts reg_wrt for MUL or DIV; a new operation may be accepted in that cycle (back-to-back).
REQ-028 SHALL use all arithmetic modulo 2^DW, with no exceptions other than the flags.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=IDLE, counter=0, ready=1, reg_wrt=0, dest=0, data=0, zero_flag=0 and carry_flag=0.
REQ-030 SHALL abort an in-flight MUL or DIV when reset asserts; no write-back occurs for it after reset releases.
REQ-031 SHALL accept operations starting from the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL check ADD of 8'hF0 and 8'h20 to dest 3: the next cycle shows reg_wrt=1, dest=3, data=8'h10, carry=1, zero=0.
REQ-033 SHALL check SUB of 5 and 5 to dest 0: reg_wrt=0, zero=1, carry=0.
REQ-034 SHALL check MUL of 8'h10 and 8'h20 to dest 7: ready=0 for 8 cycles; then reg_wrt=1, data=8'h00, carry=1, zero=1; operands are toggled mid-op to prove no effect.
REQ-035 SHALL check DIV of 100 by 7, then DIV by 0: first data=14, carry=0; second data=8'hFF, carry=1; each takes 8 cycles.
REQ-036 SHALL check MUL with rst_n pulsed low at ITER cycle 4: outputs are zero immediately; no reg_wrt follows; the next ADD completes normally.
REQ-037 SHALL check back-to-back DIV then MOV presented on the DIV completion cycle: consecutive reg_wrt pulses with correct dest and data for each.
